// File: rtl/fir_rd_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// fir_rd_sequencer_pkg
// Shared constants and types for the FIR bank read/write sequencer.
//   - State encoding of the sequencer FSM.
//   - Tap count, SRAM word width and address layout ({bank[1:0], tap[3:0]}).
//   - SRAM and multiplier latencies that set the length of the drain phase.
//   - tapInRange(): checks whether a tap index addresses a real coefficient.
// -----------------------------------------------------------------------------
package fir_rd_sequencer_pkg;

    localparam int C_NUM_TAP  = 10;
    localparam int C_DATA_W   = 16;
    localparam int C_ADDR_W   = 6;
    localparam int C_TAP_W    = 4;
    localparam int C_BANK_W   = 2;

    // One clock of SRAM read latency, one clock of multiplier latency.
    localparam int C_SRAM_LAT  = 1;
    localparam int C_MUL_LAT   = 1;
    localparam int C_DRAIN_CYC = C_SRAM_LAT + C_MUL_LAT;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_UPDATE = 2'b01,
        ST_RUN    = 2'b10,
        ST_DRAIN  = 2'b11
    } seqState_t;

    function automatic logic tapInRange(input logic [C_TAP_W-1:0] tap, input int numTap);
        return int'(tap) < numTap;
    endfunction

endpackage

// File: rtl/fir_rd_sequencer_if.sv
// -----------------------------------------------------------------------------
// fir_rd_sequencer_if
// Host coefficient-write port (valid/ready) of the FIR read sequencer.
//   iCoeffWrValid  host -> seq   write request
//   oCoeffWrReady  seq  -> host  write accepted this cycle
//   iCoeffWrAddr   host -> seq   {bank[1:0], tap[3:0]}
//   iCoeffWrData   host -> seq   coefficient value
// Modports: master = host side, slave = sequencer side.
// -----------------------------------------------------------------------------
interface fir_rd_sequencer_if
    import fir_rd_sequencer_pkg::*;
#(
    parameter int P_DATA_W = C_DATA_W,
    parameter int P_ADDR_W = C_ADDR_W
);

    logic                iCoeffWrValid;
    logic                oCoeffWrReady;
    logic [P_ADDR_W-1:0] iCoeffWrAddr;
    logic [P_DATA_W-1:0] iCoeffWrData;

    modport master (
        output iCoeffWrValid,
        output iCoeffWrAddr,
        output iCoeffWrData,
        input  oCoeffWrReady
    );

    modport slave (
        input  iCoeffWrValid,
        input  iCoeffWrAddr,
        input  iCoeffWrData,
        output oCoeffWrReady
    );

endinterface

// File: rtl/fir_rd_sequencer_en_pipe.sv
// -----------------------------------------------------------------------------
// fir_en_pipe
// Two-stage shift register that turns the registered SRAM read-active flag
// into the MAC enables.
//   iClk12M   in  system clock
//   iRst      in  asynchronous active-high reset
//   rdAct_p0  in  SRAM read issued on the bus this cycle
//   enMul     out read-active delayed by the SRAM latency
//   enAddAcc  out read-active delayed by SRAM + multiplier latency
// -----------------------------------------------------------------------------
module fir_en_pipe (
    input  logic iClk12M,
    input  logic iRst,
    input  logic rdAct_p0,
    output logic enMul,
    output logic enAddAcc
);

    logic en_p1;
    logic en_p2;

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            en_p1 <= 1'b0;
            en_p2 <= 1'b0;
        end else begin
            // p0 -> p1: SRAM data valid, multiplier may fire
            en_p1 <= rdAct_p0;
            // p1 -> p2: product valid, accumulator may add
            en_p2 <= en_p1;
        end
    end

    assign enMul    = en_p1;
    assign enAddAcc = en_p2;

endmodule

// File: rtl/fir_rd_sequencer.sv
// -----------------------------------------------------------------------------
// fir_rd_sequencer
// Generates the per-sample SRAM/MAC control stream for one FIR bank
// controller: a 10-tap read sweep per sample strobe, and coefficient writes
// from a host valid/ready port while update mode is requested.
//   iClk12M        in   12 MHz system clock
//   iRst           in   asynchronous active-high reset
//   iEnSample600k  in   one-cycle sample strobe
//   iCoeffUpdReq   in   level, requests coefficient update mode
//   coeffWr        if   host write port (slave modport)
//   oCoeffFlag     out  coefficient update in progress (to bank FSM)
//   oCsnRam        out  active-low SRAM chip select
//   oWrnRam        out  active-low SRAM write enable
//   oAddrRam       out  SRAM address
//   oWtDtRam       out  SRAM write data
//   oEnMul         out  multiplier enable
//   oEnAddAcc      out  accumulator enable
//   oSampleDone    out  one-cycle pulse, sweep finished
//   oOverrun       out  sticky, strobe arrived while busy
//   oAddrErr       out  one-cycle pulse, write to a nonexistent tap rejected
// All outputs are registered.
// -----------------------------------------------------------------------------
module fir_rd_sequencer
    import fir_rd_sequencer_pkg::*;
#(
    parameter int P_NUM_TAP = C_NUM_TAP,
    parameter int P_DATA_W  = C_DATA_W,
    parameter int P_ADDR_W  = C_ADDR_W
) (
    input  logic                  iClk12M,
    input  logic                  iRst,
    input  logic                  iEnSample600k,
    input  logic                  iCoeffUpdReq,
    fir_rd_sequencer_if.slave     coeffWr,
    output logic                  oCoeffFlag,
    output logic                  oCsnRam,
    output logic                  oWrnRam,
    output logic [P_ADDR_W-1:0]   oAddrRam,
    output logic [P_DATA_W-1:0]   oWtDtRam,
    output logic                  oEnMul,
    output logic                  oEnAddAcc,
    output logic                  oSampleDone,
    output logic                  oOverrun,
    output logic                  oAddrErr
);

    localparam logic [C_TAP_W-1:0] LP_LAST_TAP = C_TAP_W'(P_NUM_TAP - 1);
    // The state register runs one clock ahead of the registered bus, so the
    // drain state lasts one extra cycle: two flush cycles appear on the bus,
    // then the done pulse is issued from the final drain count.
    localparam logic [1:0] LP_DRAIN_LAST = 2'(C_DRAIN_CYC);

    seqState_t            state, stateNxt;
    logic [C_TAP_W-1:0]   tapCnt, tapNxt;
    logic [1:0]           drainCnt, drainNxt;

    logic                 csnNxt, wrnNxt, doneNxt, errNxt;
    logic                 readyNxt, flagNxt, overrunNxt;
    logic [P_ADDR_W-1:0]  addrNxt;
    logic [P_DATA_W-1:0]  dataNxt;
    logic                 readyReg;
    logic                 wrAccept, wrIssue;
    logic                 rdAct_p0;

    assign coeffWr.oCoeffWrReady = readyReg;

    // A handshake completes on a cycle where the registered ready is high;
    // it becomes an SRAM write only if the tap actually exists.
    assign wrAccept = (state == ST_UPDATE) && coeffWr.iCoeffWrValid && readyReg;
    assign wrIssue  = wrAccept && tapInRange(coeffWr.iCoeffWrAddr[C_TAP_W-1:0], P_NUM_TAP);

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            state    <= ST_IDLE;
            tapCnt   <= '0;
            drainCnt <= '0;
        end else begin
            state    <= stateNxt;
            tapCnt   <= tapNxt;
            drainCnt <= drainNxt;
        end
    end

    always_comb begin
        stateNxt   = state;
        tapNxt     = tapCnt;
        drainNxt   = drainCnt;
        csnNxt     = 1'b1;
        wrnNxt     = 1'b1;
        addrNxt    = '0;
        dataNxt    = '0;
        doneNxt    = 1'b0;
        errNxt     = 1'b0;
        readyNxt   = 1'b0;
        flagNxt    = 1'b0;
        overrunNxt = oOverrun;

        unique case (state)
            ST_IDLE: begin
                // A sample strobe takes priority over a pending update request.
                if (iEnSample600k) begin
                    stateNxt = ST_RUN;
                    tapNxt   = '0;
                end else if (iCoeffUpdReq) begin
                    stateNxt = ST_UPDATE;
                end
            end

            ST_UPDATE: begin
                if (iEnSample600k) begin
                    overrunNxt = 1'b1;
                end
                if (wrIssue) begin
                    csnNxt  = 1'b0;
                    wrnNxt  = 1'b0;
                    addrNxt = coeffWr.iCoeffWrAddr;
                    dataNxt = coeffWr.iCoeffWrData;
                end
                errNxt = wrAccept && !wrIssue;
                // Ready drops for the cycle a write is on the bus, which
                // limits the host to one write every two clocks.
                readyNxt = iCoeffUpdReq && !wrIssue;
                // Keep the flag up through a write still on the bus when
                // update mode is being left.
                flagNxt  = iCoeffUpdReq || wrIssue;
                if (!iCoeffUpdReq) begin
                    stateNxt = ST_IDLE;
                end
            end

            ST_RUN: begin
                if (iEnSample600k) begin
                    overrunNxt = 1'b1;
                end
                csnNxt  = 1'b0;
                addrNxt = {{(P_ADDR_W-C_TAP_W){1'b0}}, tapCnt};
                if (tapCnt == LP_LAST_TAP) begin
                    stateNxt = ST_DRAIN;
                    drainNxt = '0;
                end else begin
                    tapNxt = tapCnt + 1'b1;
                end
            end

            ST_DRAIN: begin
                if (iEnSample600k) begin
                    overrunNxt = 1'b1;
                end
                if (drainCnt == LP_DRAIN_LAST) begin
                    doneNxt  = 1'b1;
                    stateNxt = iCoeffUpdReq ? ST_UPDATE : ST_IDLE;
                end else begin
                    drainNxt = drainCnt + 1'b1;
                end
            end

            default: begin
                stateNxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge iClk12M or posedge iRst) begin
        if (iRst) begin
            oCsnRam     <= 1'b1;
            oWrnRam     <= 1'b1;
            oAddrRam    <= '0;
            oWtDtRam    <= '0;
            oSampleDone <= 1'b0;
            oAddrErr    <= 1'b0;
            oOverrun    <= 1'b0;
            oCoeffFlag  <= 1'b0;
            readyReg    <= 1'b0;
        end else begin
            oCsnRam     <= csnNxt;
            oWrnRam     <= wrnNxt;
            oAddrRam    <= addrNxt;
            oWtDtRam    <= dataNxt;
            oSampleDone <= doneNxt;
            oAddrErr    <= errNxt;
            oOverrun    <= overrunNxt;
            oCoeffFlag  <= flagNxt;
            readyReg    <= readyNxt;
        end
    end

    // A read is on the bus when selected and not writing.
    assign rdAct_p0 = !oCsnRam && oWrnRam;

    fir_en_pipe uEnPipe (
        .iClk12M  (iClk12M),
        .iRst     (iRst),
        .rdAct_p0 (rdAct_p0),
        .enMul    (oEnMul),
        .enAddAcc (oEnAddAcc)
    );

endmodule

// File: tb/tb_fir_rd_sequencer.sv
module tb_fir_rd_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        strobe = 1'b0;
    logic        req = 1'b0;
    logic        coeffFlag, csn, wrn, enMul, enAcc, done, overrun, addrErr;
    logic [5:0]  addr;
    logic [15:0] wtDt;

    int nPass  = 0;
    int nTotal = 0;

    always #5 clk = ~clk;

    fir_rd_sequencer_if #(.P_DATA_W(16), .P_ADDR_W(6)) coeffIf ();

    fir_rd_sequencer #(.P_NUM_TAP(10), .P_DATA_W(16), .P_ADDR_W(6)) dut (
        .iClk12M       (clk),
        .iRst          (rst),
        .iEnSample600k (strobe),
        .iCoeffUpdReq  (req),
        .coeffWr       (coeffIf.slave),
        .oCoeffFlag    (coeffFlag),
        .oCsnRam       (csn),
        .oWrnRam       (wrn),
        .oAddrRam      (addr),
        .oWtDtRam      (wtDt),
        .oEnMul        (enMul),
        .oEnAddAcc     (enAcc),
        .oSampleDone   (done),
        .oOverrun      (overrun),
        .oAddrErr      (addrErr)
    );

    typedef struct {
        logic       csn;
        logic [5:0] addr;
        logic       enMul;
        logic       enAcc;
        logic       done;
    } sweepVec_t;

    sweepVec_t tbl [15];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nTotal++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic checkIdleBus(input string tag);
        check({tag, " csn"},  32'(csn),  32'(1));
        check({tag, " wrn"},  32'(wrn),  32'(1));
        check({tag, " addr"}, 32'(addr), 32'(0));
        check({tag, " data"}, 32'(wtDt), 32'(0));
        check({tag, " enMul"}, 32'(enMul), 32'(0));
        check({tag, " enAcc"}, 32'(enAcc), 32'(0));
    endtask

    // Strobe sampled at edge T; k counts edges after T.
    task automatic runSweep(input int strobe2At, input int reqAt);
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int k = 0; k < 15; k++) begin
            if (k > 0) begin
                if (k == strobe2At) strobe = 1'b1;
                if (k == reqAt) req = 1'b1;
                tick();
                strobe = 1'b0;
            end
            check($sformatf("sweep k%0d csn", k),   32'(csn),   32'(tbl[k].csn));
            check($sformatf("sweep k%0d wrn", k),   32'(wrn),   32'(1));
            check($sformatf("sweep k%0d addr", k),  32'(addr),  32'(tbl[k].addr));
            check($sformatf("sweep k%0d enMul", k), 32'(enMul), 32'(tbl[k].enMul));
            check($sformatf("sweep k%0d enAcc", k), 32'(enAcc), 32'(tbl[k].enAcc));
            check($sformatf("sweep k%0d done", k),  32'(done),  32'(tbl[k].done));
            check($sformatf("sweep k%0d ready", k), 32'(coeffIf.oCoeffWrReady),
                  32'(reqAt >= 0 && k >= 14));
            check($sformatf("sweep k%0d flag", k),  32'(coeffFlag), 32'(reqAt >= 0 && k >= 14));
        end
    endtask

    initial begin
        // Expected sweep: reads T+1..T+10 (taps 0..9), enMul T+2..T+11,
        // enAddAcc T+3..T+12, done at T+13.
        for (int k = 0; k < 15; k++) begin
            tbl[k].csn   = !(k >= 1 && k <= 10);
            tbl[k].addr  = (k >= 1 && k <= 10) ? 6'(k - 1) : 6'd0;
            tbl[k].enMul = (k >= 2 && k <= 11);
            tbl[k].enAcc = (k >= 3 && k <= 12);
            tbl[k].done  = (k == 13);
        end

        coeffIf.iCoeffWrValid = 1'b0;
        coeffIf.iCoeffWrAddr  = 6'd0;
        coeffIf.iCoeffWrData  = 16'd0;

        // Asynchronous reset, before any clock edge
        #2 rst = 1'b1;
        #1;
        checkIdleBus("reset");
        check("reset done",    32'(done),    32'(0));
        check("reset overrun", 32'(overrun), 32'(0));
        check("reset addrErr", 32'(addrErr), 32'(0));
        check("reset flag",    32'(coeffFlag), 32'(0));
        check("reset ready",   32'(coeffIf.oCoeffWrReady), 32'(0));
        tick();
        rst = 1'b0;
        tick();

        // Single sweep from IDLE
        runSweep(-1, -1);
        check("sweep1 overrun", 32'(overrun), 32'(0));
        tick();

        // Second strobe at T+5: overrun set, sweep unchanged
        runSweep(5, -1);
        check("ovr overrun", 32'(overrun), 32'(1));
        rst = 1'b1;
        #1;
        check("ovr cleared", 32'(overrun), 32'(0));
        tick();
        rst = 1'b0;
        tick();

        // Coefficient write
        req = 1'b1;
        tick();
        tick();
        check("upd ready", 32'(coeffIf.oCoeffWrReady), 32'(1));
        check("upd flag",  32'(coeffFlag), 32'(1));
        check("upd csn idle", 32'(csn), 32'(1));
        coeffIf.iCoeffWrValid = 1'b1;
        coeffIf.iCoeffWrAddr  = 6'h13;
        coeffIf.iCoeffWrData  = 16'hA5A5;
        tick();
        coeffIf.iCoeffWrValid = 1'b0;
        check("wr csn",   32'(csn),  32'(0));
        check("wr wrn",   32'(wrn),  32'(0));
        check("wr addr",  32'(addr), 32'(6'h13));
        check("wr data",  32'(wtDt), 32'(16'hA5A5));
        check("wr flag",  32'(coeffFlag), 32'(1));
        check("wr ready", 32'(coeffIf.oCoeffWrReady), 32'(0));
        check("wr enMul", 32'(enMul), 32'(0));
        tick();
        check("wr end csn",   32'(csn), 32'(1));
        check("wr end ready", 32'(coeffIf.oCoeffWrReady), 32'(1));
        tick();
        check("wr enMul after", 32'(enMul), 32'(0));

        // Rejected write to tap 12
        coeffIf.iCoeffWrValid = 1'b1;
        coeffIf.iCoeffWrAddr  = 6'h0C;
        coeffIf.iCoeffWrData  = 16'h1234;
        tick();
        coeffIf.iCoeffWrValid = 1'b0;
        check("bad addrErr", 32'(addrErr), 32'(1));
        check("bad csn",     32'(csn), 32'(1));
        check("bad wrn",     32'(wrn), 32'(1));
        tick();
        check("bad addrErr end", 32'(addrErr), 32'(0));
        check("bad csn end",     32'(csn), 32'(1));

        // Strobe in UPDATE: ignored, overrun set
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        check("updStb overrun", 32'(overrun), 32'(1));
        tick();
        check("updStb csn",  32'(csn), 32'(1));
        check("updStb flag", 32'(coeffFlag), 32'(1));

        // Leave update mode
        req = 1'b0;
        tick();
        check("leave flag",  32'(coeffFlag), 32'(0));
        check("leave ready", 32'(coeffIf.oCoeffWrReady), 32'(0));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Deferred update: request rises at T+4, UPDATE visible at T+14
        runSweep(-1, 4);
        req = 1'b0;
        tick();
        tick();
        check("defer leave flag", 32'(coeffFlag), 32'(0));

        // Reset mid-sweep at tap 5
        strobe = 1'b1;
        tick();
        strobe = 1'b0;
        for (int k = 1; k <= 6; k++) tick();
        check("mid addr",  32'(addr),  32'(5));
        check("mid csn",   32'(csn),   32'(0));
        check("mid enMul", 32'(enMul), 32'(1));
        rst = 1'b1;
        #1;
        checkIdleBus("midrst");
        check("midrst done", 32'(done), 32'(0));
        tick();
        rst = 1'b0;
        tick();
        tick();
        checkIdleBus("aborted");
        for (int k = 0; k < 12; k++) begin
            tick();
            check($sformatf("aborted done k%0d", k), 32'(done), 32'(0));
        end

        $display("%0d/%0d checks passed", nPass, nTotal);
        $finish;
    end

endmodule
